// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory, latches the returned word into the IR and presents the
// decoded fields to the control unit and register file. Fetching stops on the
// halt opcode or when memory fails to acknowledge within TIMEOUT cycles.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]        HALT_OP  = 6'b111111,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Run,
  input  logic              Stall,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemAck,
  input  logic [31:0]       IMemData,
  output logic [5:0]        Op,
  output logic [4:0]        Rs,
  output logic [4:0]        Rt,
  output logic [4:0]        Rd,
  output logic [15:0]       Imm,
  output logic              InstrValid,
  output logic              Halted,
  output logic              FetchErr,
  output logic [15:0]       InstrCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetchState_t;

  // The timeout fires on the edge that would bring the wait count to TIMEOUT,
  // so the comparison is against TIMEOUT-1 held in the counter beforehand.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  fetchState_t       state;
  fetchState_t       nextState;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [7:0]        timeoutCnt;
  logic              fetchErr;
  logic [15:0]       instrCount;
  logic              timeoutHit;
  logic              isHaltOp;
  logic              imemReq;
  logic              instrValid;
  logic              halted;

  assign timeoutHit = (timeoutCnt == TIMEOUT_LAST);
  assign isHaltOp   = (ir[31:26] == HALT_OP);

  // State register; reset drops straight back to IDLE so IMemReq falls
  // without waiting for a clock edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state selection; an ack on the timeout edge takes priority over the error.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (Run) begin
          nextState = FETCH;
        end
      end
      FETCH: begin
        if (IMemAck) begin
          nextState = ISSUE;
        end else if (timeoutHit) begin
          nextState = HALT;
        end
      end
      ISSUE: begin
        if (!Stall) begin
          if (isHaltOp) begin
            nextState = HALT;
          end else if (Run) begin
            nextState = FETCH;
          end else begin
            nextState = IDLE;
          end
        end
      end
      HALT: begin
        nextState = HALT;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Moore outputs decoded purely from the current state.
  always_comb begin
    imemReq    = 1'b0;
    instrValid = 1'b0;
    halted     = 1'b0;
    case (state)
      FETCH:   imemReq    = 1'b1;
      ISSUE:   instrValid = 1'b1;
      HALT:    halted     = 1'b1;
      default: begin
        imemReq    = 1'b0;
        instrValid = 1'b0;
        halted     = 1'b0;
      end
    endcase
  end

  // PC and IR only move on an accepted ack, so Op stays stable everywhere else.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc <= RESET_PC;
      ir <= '0;
    end else if (state == FETCH && IMemAck) begin
      ir <= IMemData;
      pc <= pc + ADDR_W'(4);
    end
  end

  // Ack wait counter and sticky error flag; the counter is kept at zero
  // outside FETCH so every fetch starts a fresh budget.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      timeoutCnt <= '0;
      fetchErr   <= 1'b0;
    end else if (state == FETCH) begin
      if (IMemAck) begin
        timeoutCnt <= '0;
      end else if (timeoutHit) begin
        timeoutCnt <= '0;
        fetchErr   <= 1'b1;
      end else begin
        timeoutCnt <= timeoutCnt + 8'd1;
      end
    end else begin
      timeoutCnt <= '0;
    end
  end

  // Count each instruction handed to the consumer, including the halt opcode.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      instrCount <= '0;
    end else if (state == ISSUE && !Stall) begin
      instrCount <= instrCount + 16'd1;
    end
  end

  assign IMemReq    = imemReq;
  assign IMemAddr   = pc;
  assign InstrValid = instrValid;
  assign Halted     = halted;
  assign FetchErr   = fetchErr;
  assign InstrCount = instrCount;
  assign Op         = ir[31:26];
  assign Rs         = ir[25:21];
  assign Rt         = ir[20:16];
  assign Rd         = ir[15:11];
  assign Imm        = ir[15:0];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetch stage; sits directly upstream of the control unit and drives its 6-bit Op input.
- Holds the PC and runs a req/ack handshake with instruction memory.
- Latches the returned word into an instruction register (IR) and presents decoded fields to the control unit and register file.
- Supports consumer stall, a halt opcode, and an ack-timeout error.

Parameters:
ADDR_W, 32, PC / instruction-memory address width
RESET_PC, 0, PC value loaded on reset
HALT_OP, 6'b111111, opcode that stops fetching after issue
TIMEOUT, 15, max cycles FETCH waits for ack before error (1..255)

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous active-low reset
Run  in  1  enable fetching; sampled in IDLE and ISSUE
Stall  in  1  consumer not ready; holds ISSUE
IMemReq  out  1  fetch request to instruction memory
IMemAddr  out  ADDR_W  fetch address (= PC)
IMemAck  in  1  memory returns IMemData this cycle
IMemData  in  32  instruction word
Op  out  6  IR[31:26], to control unit Op
Rs  out  5  IR[25:21]
Rt  out  5  IR[20:16]
Rd  out  5  IR[15:11]
Imm  out  16  IR[15:0]
InstrValid  out  1  IR holds a freshly fetched instruction
Halted  out  1  HALT_OP issued; fetching stopped
FetchErr  out  1  sticky: ack timeout occurred
InstrCount  out  16  issued-instruction counter, wraps 0xFFFF->0

Behaviour:
- Reset (async, Rst_n=0):
  - PC=RESET_PC, IR=0 (so Op=0, the control unit's no-write default), state=IDLE.
  - InstrValid=0, IMemReq=0, Halted=0, FetchErr=0, InstrCount=0, timeout counter=0.
  - Assertion mid-fetch drops IMemReq immediately; any in-flight ack after release is ignored.
- Outputs are Moore:
  - IMemReq = (state==FETCH).
  - InstrValid = (state==ISSUE).
  - Halted = (state==HALT).
  - Op/Rs/Rt/Rd/Imm are wired directly from IR.
  - IMemAddr = PC.
- IDLE: IMemReq=0. Goes to FETCH when Run=1.
- FETCH:
  - IMemReq=1, IMemAddr=PC, both held stable until ack.
  - On an edge with IMemAck=1: IR<=IMemData, PC<=PC+4 (modulo 2^ADDR_W, wraps silently), timeout counter<=0, next state ISSUE.
  - Each edge with IMemAck=0 increments the timeout counter.
  - When the counter reaches TIMEOUT with no ack: FetchErr<=1, next state HALT. Ack arriving on the same edge as the TIMEOUT-th count wins, with no error.
  - Minimum fetch latency: ack in the first FETCH cycle, giving ISSUE on the next edge.
- ISSUE:
  - InstrValid=1; IR stable.
  - Stall=1: remain in ISSUE, IR and PC unchanged.
  - Stall=0:
    - InstrCount<=InstrCount+1.
    - If Op==HALT_OP, go to HALT.
    - Else if Run=1, go to FETCH.
    - Else go to IDLE.
  - IR is only written on an accepted ack, so Op stays stable through IDLE and FETCH. The control unit registers its outputs on Clk one edge after ISSUE entry.
- HALT: IMemReq=0. Terminal until reset; Run, Stall and IMemAck are ignored.
- IMemAck outside FETCH is ignored; it changes no state.
- Back-to-back throughput: 2 cycles per instruction (FETCH, ISSUE) with immediate ack and no stall.
- Run deasserted during FETCH does not abort the fetch; it takes effect at ISSUE exit.

Test Plan:
- Reset then Run=1; memory acks immediately with 0x04221800 (Op=6'b000001) at PC 0 and 0x08A30004 (Op=6'b000010) at PC 4 -> IMemAddr 0 then 4. Op=6'b000001 then 6'b000010 while InstrValid=1. Each InstrValid lasts 1 cycle, 2-cycle period. InstrCount=2.
- Ack delayed 3 cycles -> IMemReq high for 4 cycles with IMemAddr constant. IR changes only on the ack edge. FetchErr=0.
- Stall=1 for 5 cycles in ISSUE -> InstrValid high 6 cycles, PC unchanged, no IMemReq. Fetch resumes the edge after Stall drops.
- Fetch of 0xFC000000 (HALT_OP) -> one ISSUE, then Halted=1, IMemReq stays 0 despite Run=1 and spurious acks. InstrCount includes the halt instruction.
- No ack for TIMEOUT=15 cycles -> FetchErr=1 and Halted=1 on the 15th edge. Second run with ack on exactly the 15th cycle -> normal ISSUE, FetchErr=0.
- RESET_PC=0xFFFFFFFC, one fetch -> PC wraps to 0x00000000. Rst_n pulsed low mid-FETCH -> IMemReq drops without waiting for a clock, Op=0, PC=RESET_PC.
